// File: rtl/exe_cond_stage.sv
// exe_cond_stage
// ARM-style conditional-execution gate in front of the EXE stage register.
// An instruction presented on the decode side is either registered into EXE
// (condition passes) or turned into a bubble (condition fails / no
// instruction). Condition flags are taken from the architectural status
// register, or bypassed straight from alu_flags when the instruction
// currently in EXE is a flag-setter, so back-to-back CMP/Bcc pairs resolve
// without a stall.
//
// Ports
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   freeze              : hold stage register, status register and counter
//   flush               : load a bubble (wins over freeze)
//   in_valid, cond      : decoded instruction present, its condition field
//   *_in                : decoded controls / ALU command / destination
//   alu_flags           : {Z,C,N,V} produced by the EXE occupant this cycle
//   valid_out, *_out    : registered EXE-stage controls
//   status_out          : architectural {Z,C,N,V}
//   squash_cnt          : saturating count of condition-failed instructions
module exe_cond_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [3:0]  cond,
  input  logic        wb_en_in,
  input  logic        mem_r_en_in,
  input  logic        mem_w_en_in,
  input  logic        s_in,
  input  logic        b_in,
  input  logic [3:0]  exe_cmd_in,
  input  logic [3:0]  dest_in,
  input  logic [3:0]  alu_flags,
  output logic        valid_out,
  output logic        wb_en_out,
  output logic        mem_r_en_out,
  output logic        mem_w_en_out,
  output logic        s_out,
  output logic        b_out,
  output logic [3:0]  exe_cmd_out,
  output logic [3:0]  dest_out,
  output logic [3:0]  status_out,
  output logic [15:0] squash_cnt
);

  typedef struct packed {
    logic       valid;
    logic       wbEn;
    logic       memREn;
    logic       memWEn;
    logic       s;
    logic       b;
    logic [3:0] exeCmd;
    logic [3:0] dest;
  } stage_t;

  localparam stage_t Bubble = '0;

  stage_t      stageReg, stageNext;
  logic [3:0]  statusReg, statusNext;
  logic [15:0] squashReg, squashNext;

  logic [3:0]  flagsEff;
  logic        flagZ, flagC, flagN, flagV;
  logic        condBase;
  logic        condPass;
  logic        flagSetter;

  // The EXE occupant's flags are not architectural yet; bypass them.
  assign flagSetter = stageReg.valid & stageReg.s;
  assign flagsEff   = flagSetter ? alu_flags : statusReg;
  assign flagZ      = flagsEff[3];
  assign flagC      = flagsEff[2];
  assign flagN      = flagsEff[1];
  assign flagV      = flagsEff[0];

  // Conditions come in complementary pairs: cond[3:1] selects the base
  // test and cond[0] inverts it. The 1111 slot is "never", not "not always".
  always_comb begin
    condBase = 1'b0;
    unique case (cond[3:1])
      3'd0: condBase = flagZ;
      3'd1: condBase = flagC;
      3'd2: condBase = flagN;
      3'd3: condBase = flagV;
      3'd4: condBase = flagC & ~flagZ;
      3'd5: condBase = (flagN == flagV);
      3'd6: condBase = ~flagZ & (flagN == flagV);
      3'd7: condBase = 1'b1;
      default: condBase = 1'b0;
    endcase
    condPass = (cond == 4'b1111) ? 1'b0 : (condBase ^ cond[0]);
  end

  always_comb begin
    stageNext  = stageReg;
    squashNext = squashReg;
    statusNext = statusReg;

    // Status commits whenever a flag-setter leaves EXE unstalled, even if
    // the younger instruction behind it is being flushed.
    if (flagSetter && !freeze) begin
      statusNext = alu_flags;
    end

    if (flush) begin
      stageNext = Bubble;
    end else if (!freeze) begin
      if (in_valid && condPass) begin
        stageNext.valid  = 1'b1;
        stageNext.wbEn   = wb_en_in;
        stageNext.memREn = mem_r_en_in;
        stageNext.memWEn = mem_w_en_in;
        stageNext.s      = s_in;
        stageNext.b      = b_in;
        stageNext.exeCmd = exe_cmd_in;
        stageNext.dest   = dest_in;
      end else begin
        stageNext = Bubble;
        if (in_valid && (squashReg != 16'hFFFF)) begin
          squashNext = squashReg + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stageReg  <= Bubble;
      statusReg <= 4'b0000;
      squashReg <= 16'd0;
    end else begin
      stageReg  <= stageNext;
      statusReg <= statusNext;
      squashReg <= squashNext;
    end
  end

  assign valid_out    = stageReg.valid;
  assign wb_en_out    = stageReg.wbEn;
  assign mem_r_en_out = stageReg.memREn;
  assign mem_w_en_out = stageReg.memWEn;
  assign s_out        = stageReg.s;
  assign b_out        = stageReg.b;
  assign exe_cmd_out  = stageReg.exeCmd;
  assign dest_out     = stageReg.dest;
  assign status_out   = statusReg;
  assign squash_cnt   = squashReg;

endmodule
